// File: rtl/j1_stack.sv
// j1_stack: circular data stack for a J1-style CPU.
// The top of stack is cached in a register (tos); the cell at the pointer is
// next-on-stack (nos). The block tracks occupancy with sticky overflow and
// underflow flags, and has a registered debug peek port that works while stalled.
module j1_stack #(
    parameter int WIDTH     = 16,
    parameter int DEPTHBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           delta,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH-1:0]     tos_next,
    output logic [WIDTH-1:0]     tos,
    output logic [WIDTH-1:0]     nos,
    output logic [DEPTHBITS-1:0] ptr,
    output logic [DEPTHBITS:0]   count,
    output logic                 ovf,
    output logic                 unf,
    input  logic                 clr_flags,
    input  logic                 peek_req,
    input  logic [DEPTHBITS-1:0] peek_idx,
    output logic                 peek_valid,
    output logic [WIDTH-1:0]     peek_data
);

    localparam int DEPTH = 1 << DEPTHBITS;
    localparam logic [DEPTHBITS:0] FULL = (DEPTHBITS + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTHBITS+1:0] delta_ext;
    logic [DEPTHBITS+1:0] occ_sum;
    logic [DEPTHBITS-1:0] ptr_new;
    logic [DEPTHBITS:0]   count_new;
    logic                 occ_over;
    logic                 occ_under;

    // Pointer and occupancy arithmetic; occ_sum is a signed DEPTHBITS+2 bit value.
    always_comb begin
        delta_ext = {{DEPTHBITS{delta[1]}}, delta};
        ptr_new   = ptr + delta_ext[DEPTHBITS-1:0];
        occ_sum   = {1'b0, count} + delta_ext;
        occ_under = occ_sum[DEPTHBITS+1];
        occ_over  = !occ_under && (occ_sum[DEPTHBITS:0] > FULL);
        count_new = occ_sum[DEPTHBITS:0];
        if (occ_under) begin
            count_new = '0;
        end else if (occ_over) begin
            count_new = FULL;
        end
    end

    assign nos = mem[ptr];

    // Architectural state: pointer, occupancy, cached TOS and sticky flags.
    // A new overflow/underflow event takes precedence over clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            tos   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            ptr   <= ptr_new;
            count <= count_new;
            tos   <= tos_next;
            ovf   <= occ_over  | (ovf & ~clr_flags);
            unf   <= occ_under | (unf & ~clr_flags);
        end
    end

    // Cell write at the post-move pointer; cells are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && en && wr) begin
            mem[ptr_new] <= wdata;
        end
    end

    // Debug peek: samples pre-edge pointer and memory, independent of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            peek_valid <= 1'b0;
            peek_data  <= '0;
        end else begin
            peek_valid <= peek_req;
            if (peek_req) begin
                peek_data <= mem[ptr - peek_idx];
            end
        end
    end

endmodule

// File: tb/tb_j1_stack.sv
// Testbench for j1_stack (depth 4) with directed scenarios and a randomized
// run compared against a behavioural stack model.
module tb_j1_stack;

    localparam int W     = 16;
    localparam int DB    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, en, wr, clr_flags, peek_req;
    logic [1:0]    delta;
    logic [W-1:0]  wdata, tos_next;
    logic [DB-1:0] peek_idx;
    logic [W-1:0]  tos, nos, peek_data;
    logic [DB-1:0] ptr;
    logic [DB:0]   count;
    logic          ovf, unf, peek_valid;

    j1_stack #(.WIDTH(W), .DEPTHBITS(DB)) dut (
        .clk(clk), .reset(reset), .en(en), .delta(delta), .wr(wr),
        .wdata(wdata), .tos_next(tos_next), .tos(tos), .nos(nos),
        .ptr(ptr), .count(count), .ovf(ovf), .unf(unf),
        .clr_flags(clr_flags), .peek_req(peek_req), .peek_idx(peek_idx),
        .peek_valid(peek_valid), .peek_data(peek_data)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model state
    int           m_ptr, m_count;
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] m_tos, m_pd;
    bit           m_ovf, m_unf, m_pv;
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // Driver: apply inputs for one edge, advance the model, sample 1 time unit later.
    task automatic cycle(input bit r, input bit e, input int d, input bit w,
                         input logic [W-1:0] wd, input logic [W-1:0] tn,
                         input bit c, input bit pr, input int pi);
        int np;
        int s;
        reset = r; en = e; delta = 2'(d); wr = w; wdata = wd; tos_next = tn;
        clr_flags = c; peek_req = pr; peek_idx = DB'(pi);
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_count = 0; m_tos = '0; m_ovf = 0; m_unf = 0;
            m_pv = 0; m_pd = '0;
            exp_q.delete();
        end else begin
            m_pv = pr;
            if (pr) begin
                m_pd = m_mem[(m_ptr - pi + DEPTH) % DEPTH];
                exp_q.push_back(m_pd);
            end
            if (e) begin
                np = (m_ptr + d + DEPTH) % DEPTH;
                if (w) m_mem[np] = wd;
                m_ptr = np;
                m_tos = tn;
                s = m_count + d;
                if (c) begin m_ovf = 0; m_unf = 0; end
                if (s > DEPTH) begin m_count = DEPTH; m_ovf = 1; end
                else if (s < 0) begin m_count = 0; m_unf = 1; end
                else m_count = s;
            end
        end
        #1;
    endtask

    // Write every cell once so nos and peek are defined everywhere, then reset.
    task automatic test_reset();
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 1, 1, 1, W'($urandom), W'($urandom), 0, 0, 0);
        cycle(0, 0, 0, 0, '0, '0, 0, 1, 0);
        cycle(1, 1, 1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 0);
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (tos !== 16'h0) begin errors++; $display("FAIL reset_tos: got %h expected 0000", tos); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
        checks++; if (peek_valid !== 1'b0 || peek_data !== 16'h0) begin errors++; $display("FAIL reset_peek: got valid=%b data=%h expected 0 0000", peek_valid, peek_data); end
    endtask

    task automatic test_push_drop();
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        cycle(0, 1, 1, 1, 16'h1111, 16'h0AAA, 0, 0, 0);
        cycle(0, 1, 1, 1, 16'h2222, 16'h0BBB, 0, 0, 0);
        cycle(0, 1, 1, 1, 16'h3333, 16'h0CCC, 0, 0, 0);
        checks++; if (ptr !== 2'd3) begin errors++; $display("FAIL push_ptr: got %0d expected 3", ptr); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL push_count: got %0d expected 3", count); end
        checks++; if (nos !== 16'h3333) begin errors++; $display("FAIL push_nos: got %h expected 3333", nos); end
        checks++; if (tos !== 16'h0CCC) begin errors++; $display("FAIL push_tos: got %h expected 0ccc", tos); end
        cycle(0, 0, 0, 0, '0, '0, 0, 1, 2);
        checks++; if (peek_valid !== 1'b1 || peek_data !== 16'h1111) begin errors++; $display("FAIL push_peek: got valid=%b data=%h expected 1 1111", peek_valid, peek_data); end
        cycle(0, 0, 0, 0, '0, '0, 0, 0, 0);
        checks++; if (peek_valid !== 1'b0 || peek_data !== 16'h1111) begin errors++; $display("FAIL peek_hold: got valid=%b data=%h expected 0 1111", peek_valid, peek_data); end
        cycle(0, 1, -2, 0, '0, 16'h0DDD, 0, 0, 0);
        checks++; if (ptr !== 2'd1 || count !== 3'd1) begin errors++; $display("FAIL drop_ptr_count: got %0d/%0d expected 1/1", ptr, count); end
        checks++; if (nos !== 16'h1111) begin errors++; $display("FAIL drop_nos: got %h expected 1111", nos); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL drop_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
    endtask

    task automatic test_overflow();
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cycle(0, 1, 1, 1, 16'h00A0 + W'(i), '0, 0, 0, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        checks++; if (ptr !== 2'd1 || nos !== 16'h00A4) begin errors++; $display("FAIL ovf_wrap: got ptr=%0d nos=%h expected 1 00a4", ptr, nos); end
        cycle(0, 1, 0, 0, '0, '0, 1, 0, 0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    endtask

    task automatic test_underflow();
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        cycle(0, 1, -1, 0, '0, '0, 0, 0, 0);
        checks++; if (ptr !== 2'd3 || count !== 3'd0) begin errors++; $display("FAIL unf_ptr_count: got %0d/%0d expected 3/0", ptr, count); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_set: got %b expected 1", unf); end
        cycle(0, 1, -1, 0, '0, '0, 1, 0, 0);
        checks++; if (unf !== 1'b1 || ptr !== 2'd2) begin errors++; $display("FAIL unf_set_wins: got unf=%b ptr=%0d expected 1 2", unf, ptr); end
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        cycle(0, 1, -2, 0, '0, '0, 0, 0, 0);
        checks++; if (ptr !== 2'd2 || unf !== 1'b1) begin errors++; $display("FAIL unf_drop2: got ptr=%0d unf=%b expected 2 1", ptr, unf); end
    endtask

    task automatic test_peek_collision();
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        cycle(0, 1, 1, 1, 16'h1234, '0, 0, 0, 0);
        cycle(0, 1, 0, 1, 16'hBEEF, '0, 0, 1, 0);
        checks++; if (peek_valid !== 1'b1 || peek_data !== 16'h1234) begin errors++; $display("FAIL collide_peek: got valid=%b data=%h expected 1 1234", peek_valid, peek_data); end
        checks++; if (nos !== 16'hBEEF) begin errors++; $display("FAIL collide_nos: got %h expected beef", nos); end
    endtask

    task automatic test_stall_reset();
        logic [W-1:0] s_tos, s_nos, s_above;
        logic [DB-1:0] s_ptr;
        logic [DB:0] s_count;
        cycle(0, 1, 1, 1, 16'h4242, 16'h9999, 0, 0, 0);
        s_ptr = ptr; s_count = count; s_tos = tos; s_nos = nos;
        s_above = m_mem[(m_ptr + 1) % DEPTH];
        cycle(0, 0, 1, 1, 16'h5555, 16'h7777, 0, 0, 0);
        checks++; if (ptr !== s_ptr || count !== s_count) begin errors++; $display("FAIL stall_ptr_count: got %0d/%0d expected %0d/%0d", ptr, count, s_ptr, s_count); end
        checks++; if (tos !== s_tos || nos !== s_nos) begin errors++; $display("FAIL stall_tos_nos: got %h/%h expected %h/%h", tos, nos, s_tos, s_nos); end
        cycle(0, 0, 0, 0, '0, '0, 0, 1, 3);
        checks++; if (peek_valid !== 1'b1 || peek_data !== s_above) begin errors++; $display("FAIL stall_mem: got valid=%b data=%h expected 1 %h", peek_valid, peek_data, s_above); end
        cycle(0, 0, 0, 0, '0, '0, 0, 1, 0);
        cycle(1, 1, 1, 1, 16'h6666, 16'h6666, 0, 1, 0);
        checks++; if (peek_valid !== 1'b0 || peek_data !== 16'h0) begin errors++; $display("FAIL reset_peek_drop: got valid=%b data=%h expected 0 0000", peek_valid, peek_data); end
        checks++; if (ptr !== 2'd0 || count !== 3'd0 || tos !== 16'h0) begin errors++; $display("FAIL reset_state: got ptr=%0d count=%0d tos=%h expected 0 0 0000", ptr, count, tos); end
    endtask

    // Randomized run against the model; peek results also go through exp_q.
    task automatic test_random();
        int dt[4] = '{0, 1, -1, -2};
        logic [W-1:0] exp_pd;
        cycle(1, 0, 0, 0, '0, '0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
                  dt[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                  W'($urandom), W'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1));
            checks++; if (ptr !== DB'(m_ptr)) begin errors++; $display("FAIL rnd_ptr[%0d]: got %0d expected %0d", n, ptr, m_ptr); end
            checks++; if (count !== (DB + 1)'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, count, m_count); end
            checks++; if (tos !== m_tos) begin errors++; $display("FAIL rnd_tos[%0d]: got %h expected %h", n, tos, m_tos); end
            checks++; if (ovf !== m_ovf || unf !== m_unf) begin errors++; $display("FAIL rnd_flags[%0d]: got %b%b expected %b%b", n, ovf, unf, m_ovf, m_unf); end
            checks++; if (nos !== m_mem[m_ptr]) begin errors++; $display("FAIL rnd_nos[%0d]: got %h expected %h", n, nos, m_mem[m_ptr]); end
            checks++; if (peek_valid !== m_pv || peek_data !== m_pd) begin errors++; $display("FAIL rnd_peek[%0d]: got %b %h expected %b %h", n, peek_valid, peek_data, m_pv, m_pd); end
            if (peek_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_peek_q[%0d]: got unexpected strobe expected none", n);
                end else begin
                    exp_pd = exp_q.pop_front();
                    if (peek_data !== exp_pd) begin errors++; $display("FAIL rnd_peek_q[%0d]: got %h expected %h", n, peek_data, exp_pd); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_drop();
        test_overflow();
        test_underflow();
        test_peek_collision();
        test_stall_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/j1_stack.md
J1_STACK -- requirements
Module: j1_stack

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of each stack cell and of TOS.
REQ-002 Parameter DEPTHBITS, default 5, sets the stack depth DEPTH = 2**DEPTHBITS cells; the legal range is 2..8.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: step enable; when it is 0, all architectural state holds, except the peek port.
REQ-006 Port delta, input, 2 bits: signed pointer change; 00 = hold, 01 = +1, 11 = -1, 10 = -2.
REQ-007 Port wr, input, 1 bit: write wdata into the cell addressed by the new pointer.
REQ-008 Port wdata, input, WIDTH bits: data for a cell write (normally the old TOS).
REQ-009 Port tos_next, input, WIDTH bits: next value of the cached top-of-stack register.
REQ-010 Port tos, output, WIDTH bits: the cached top-of-stack register.
REQ-011 Port nos, output, WIDTH bits: the cell at the current pointer (next-on-stack), combinational read.
REQ-012 Port ptr, output, DEPTHBITS bits: the current circular stack pointer.
REQ-013 Port count, output, DEPTHBITS+1 bits: occupancy, 0..DEPTH.
REQ-014 Port ovf, output, 1 bit: sticky overflow flag.
REQ-015 Port unf, output, 1 bit: sticky underflow flag.
REQ-016 Port clr_flags, input, 1 bit: clears ovf and unf.
REQ-017 Port peek_req, input, 1 bit: debug read request.
REQ-018 Port peek_idx, input, DEPTHBITS bits: cell offset below the pointer to read.
REQ-019 Port peek_valid, output, 1 bit: one-cycle strobe marking peek_data valid.
REQ-020 Port peek_data, output, WIDTH bits: registered debug read result.

Function
REQ-021 On a rising edge with en=1, the block SHALL apply: ptr <= ptr + sign-extended delta, modulo DEPTH.
REQ-022 On a rising edge with en=1 and wr=1, the block SHALL write mem[ptr + delta] <= wdata, using the new pointer.
REQ-023 On a rising edge with en=1, the block SHALL load tos <= tos_next.
REQ-024 nos SHALL equal mem[ptr] combinationally; a write becomes visible on nos in the cycle after the edge.
REQ-025 The pointer SHALL wrap circularly with no saturation: ptr=DEPTH-1 with +1 gives 0; ptr=0 with -2 gives DEPTH-2.
REQ-026 The occupancy computation SHALL be s = count + delta, evaluated signed in DEPTHBITS+2 bits, on each enabled edge.
REQ-027 If s > DEPTH: count <= DEPTH and ovf <= 1.
REQ-028 If s < 0: count <= 0 and unf <= 1.
REQ-029 Otherwise: count <= s.
REQ-030 With en=0, count SHALL hold.
REQ-031 ovf and unf SHALL be sticky until clr_flags or reset.
REQ-032 If clr_flags is asserted in the same cycle as a new overflow or underflow event, the set SHALL win and the flag SHALL read 1 afterwards.
REQ-033 Peek: a peek_req sampled on an edge SHALL produce, on the next edge, peek_valid=1 and peek_data = mem[(ptr - peek_idx) mod DEPTH].
REQ-034 The peek read SHALL use ptr and memory contents as they were before that edge (read-before-write), including when the same cell is written on that edge.
REQ-035 peek_valid SHALL be high for exactly one cycle per request.
REQ-036 Back-to-back peek requests SHALL give back-to-back results.
REQ-037 Peek SHALL operate regardless of en.
REQ-038 When peek_valid=0, peek_data SHALL hold its last value.

Reset
REQ-039 On reset=1 at an edge: ptr=0, count=0, tos=0, ovf=0, unf=0, peek_valid=0, peek_data=0.
REQ-040 Reset SHALL take priority over en, wr, clr_flags and peek_req; a peek request pending at reset SHALL be discarded.
REQ-041 Memory cells SHALL NOT be reset; nos after reset is undefined until the cell is written.

Verification
REQ-042 Push sequence: reset; then 3 edges with en=1, delta=01, wr=1, wdata=0x1111/0x2222/0x3333 -> ptr=3, count=3, nos=0x3333; peek_idx=2 -> peek_data=0x1111 one cycle later.
REQ-043 Drop-two: from the state in REQ-042, delta=10, wr=0 -> ptr=1, count=1, nos=0x1111, ovf=0, unf=0.
REQ-044 Overflow: DEPTHBITS=2; 5 pushes of 0xA0..0xA4 -> count=4, ovf=1, ptr=1, nos=0xA4; then clr_flags=1 -> ovf=0.
REQ-045 Underflow and wrap: after reset, delta=11 -> ptr=DEPTH-1, count=0, unf=1; clr_flags together with another delta=11 -> unf stays 1.
REQ-046 Peek collision: peek_idx=0 in the same cycle as delta=00, wr=1, wdata=0xBEEF on the current cell holding 0x1234 -> peek_data=0x1234 and the following nos=0xBEEF.
REQ-047 Stall and reset: en=0 with delta=01, wr=1 -> ptr, count, tos and memory unchanged; reset asserted with peek_req=1 -> peek_valid stays 0 and all outputs are at reset values.
